// File: rtl/al422_bam_pkg.sv
// Shared FSM states, FIFO lane bit offsets and on-time width helper for the AL422 BAM driver.
package al422_bam_pkg;

  typedef enum logic [2:0] {FRST, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} state_e;

  localparam int RGB1_LSB = 0;
  localparam int RGB2_LSB = 3;

  // Bits needed to hold the longest on-time, BASE_TICKS << (BAM_BITS-1).
  function automatic int on_time_width(input int base, input int bam);
    return $clog2((base << (bam - 1)) + 1);
  endfunction

endpackage

// File: rtl/al422_bam_multi_if.sv
// FIFO read port and HUB75 panel signals; master is the driver, slave is FIFO plus panel.
interface al422_bam_multi_if #(
  parameter int CHAINS   = 1,
  parameter int ROW_BITS = 4
);
  logic [8*CHAINS-1:0]  in_data;
`ifdef AL422_BAM_MULTI_BRIGHTNESS_EN
  logic [7:0]           brightness;
`endif
  logic                 al422_re_out;
  logic                 al422_nrst_out;
  logic                 led_clk_out;
  logic                 led_lat_out;
  logic                 led_oe_out;
  logic [ROW_BITS-1:0]  led_row;
  logic [3*CHAINS-1:0]  rgb1;
  logic [3*CHAINS-1:0]  rgb2;
  logic                 frame_done;

`ifdef AL422_BAM_MULTI_BRIGHTNESS_EN
  modport master (input in_data, brightness,
                  output al422_re_out, al422_nrst_out, led_clk_out, led_lat_out,
                  led_oe_out, led_row, rgb1, rgb2, frame_done);
  modport slave  (output in_data, brightness,
                  input al422_re_out, al422_nrst_out, led_clk_out, led_lat_out,
                  led_oe_out, led_row, rgb1, rgb2, frame_done);
`else
  modport master (input in_data,
                  output al422_re_out, al422_nrst_out, led_clk_out, led_lat_out,
                  led_oe_out, led_row, rgb1, rgb2, frame_done);
  modport slave  (output in_data,
                  input al422_re_out, al422_nrst_out, led_clk_out, led_lat_out,
                  led_oe_out, led_row, rgb1, rgb2, frame_done);
`endif
endinterface

// File: rtl/al422_bam_timer.sv
// Loadable down-counter shared by FRST, BLANK and DISPLAY; holds at zero, load wins over count.
module al422_bam_timer #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);
endmodule

// File: rtl/al422_bam_multi.sv
// AL422 to multi-chain HUB75 BAM driver: column shift, blank, latch, binary-weighted display per row.
// AL422_BAM_MULTI_BRIGHTNESS_EN adds a brightness input that trims each DISPLAY on-time.
module al422_bam_multi
  import al422_bam_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int BAM_BITS   = 6,
  parameter int CHAINS     = 1,
  parameter int BASE_TICKS = 32,
  parameter int DEAD_TICKS = 2
) (
  input  logic              in_clk,
  input  logic              in_nrst,
  al422_bam_multi_if.master bus
);
  localparam int CW  = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int PW  = (BAM_BITS > 1) ? $clog2(BAM_BITS) : 1;
  localparam int OTW = on_time_width(BASE_TICKS, BAM_BITS);
  localparam int DTW = $clog2(DEAD_TICKS + 1);
  localparam int TW  = (OTW > DTW) ? OTW : DTW;

  localparam logic [CW-1:0]       COL_LAST   = CW'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;
  localparam logic [PW-1:0]       PLANE_LAST = PW'(BAM_BITS - 1);

  state_e                state_d, state_q;
  logic [CW-1:0]         col_d, col_q;
  logic [ROW_BITS-1:0]   row_d, row_q, led_row_d, led_row_q;
  logic [PW-1:0]         plane_d, plane_q;
  logic [3*CHAINS-1:0]   rgb1_d, rgb1_q, rgb2_d, rgb2_q;
  logic [TW-1:0]         on_d, on_q, on_next, len, tmr_val, tmr_cnt;
  logic                  re_d, re_q, nrst_out_d, nrst_out_q, sclk_d, sclk_q;
  logic                  lat_d, lat_q, oe_d, oe_q, frame_done_d, frame_done_q;
  logic                  tmr_load, tmr_done, disp_on;
  logic                  unused_lane_bits;

  assign len = TW'(BASE_TICKS) << plane_q;

`ifdef AL422_BAM_MULTI_BRIGHTNESS_EN
  logic [TW+8:0] on_prod;
  assign on_prod = (TW+9)'(len) * (TW+9)'({1'b0, bus.brightness} + 9'd1);
  assign on_next = TW'(on_prod >> 8);
`else
  assign on_next = len;
`endif

  al422_bam_timer #(.W(TW), .RST_VAL(1)) u_timer (
    .clk      (in_clk),
    .nrst     (in_nrst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    plane_d   = plane_q;
    led_row_d = led_row_q;
    rgb1_d    = rgb1_q;
    rgb2_d    = rgb2_q;
    on_d      = on_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      FRST: if (tmr_done) state_d = SHIFT_LO;
      SHIFT_LO: begin
        state_d = SHIFT_HI;
        for (int c = 0; c < CHAINS; c++) begin
          rgb1_d[3*c +: 3] = bus.in_data[8*c + RGB1_LSB +: 3];
          rgb2_d[3*c +: 3] = bus.in_data[8*c + RGB2_LSB +: 3];
        end
      end
      SHIFT_HI: begin
        if (col_q == COL_LAST) begin
          col_d    = '0;
          state_d  = BLANK;
          tmr_load = 1'b1;
          tmr_val  = TW'(DEAD_TICKS - 1);
        end else begin
          col_d   = col_q + CW'(1);
          state_d = SHIFT_LO;
        end
      end
      BLANK: begin
        if (tmr_done) begin
          state_d = LATCH;
          on_d    = on_next;
        end
      end
      LATCH: begin
        state_d  = DISPLAY;
        tmr_load = 1'b1;
        tmr_val  = len - TW'(1);
      end
      DISPLAY: begin
        if (tmr_done) begin
          state_d = SHIFT_LO;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (plane_q == PLANE_LAST) begin
              plane_d  = '0;
              state_d  = FRST;
              tmr_load = 1'b1;
              tmr_val  = TW'(1);
            end else begin
              plane_d = plane_q + PW'(1);
            end
          end else begin
            row_d = row_q + ROW_BITS'(1);
          end
        end
      end
      default: state_d = FRST;
    endcase

    if (state_d == LATCH) led_row_d = row_q;

    // Next DISPLAY tick is len - tmr_cnt; it is lit while that tick is below on_q.
    disp_on = (state_q == DISPLAY) ? (({1'b0, tmr_cnt} + {1'b0, on_q}) > {1'b0, len})
                                   : (on_q != '0);

    re_d         = (state_d != SHIFT_LO);
    nrst_out_d   = (state_d != FRST);
    sclk_d       = (state_d == SHIFT_HI);
    lat_d        = (state_d == LATCH);
    oe_d         = !((state_d == DISPLAY) && disp_on);
    frame_done_d = (state_q == DISPLAY) && (state_d == FRST);
  end

  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      state_q      <= FRST;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      led_row_q    <= '0;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      on_q         <= '0;
      re_q         <= 1'b1;
      nrst_out_q   <= 1'b0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      led_row_q    <= led_row_d;
      rgb1_q       <= rgb1_d;
      rgb2_q       <= rgb2_d;
      on_q         <= on_d;
      re_q         <= re_d;
      nrst_out_q   <= nrst_out_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Lane bits [7:6] carry nothing for the panel.
  assign unused_lane_bits = ^bus.in_data;

  assign bus.al422_re_out   = re_q;
  assign bus.al422_nrst_out = nrst_out_q;
  assign bus.led_clk_out    = sclk_q;
  assign bus.led_lat_out    = lat_q;
  assign bus.led_oe_out     = oe_q;
  assign bus.led_row        = led_row_q;
  assign bus.rgb1           = rgb1_q;
  assign bus.rgb2           = rgb2_q;
  assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_al422_bam_multi.sv
// Directed bench: two-chain driver with a small FIFO model; frame timing, data mapping, resets.
module tb_al422_bam_multi;
  typedef struct {
    logic [15:0] word;
    logic [5:0]  rgb1;
    logic [5:0]  rgb2;
  } vec_t;

  logic        in_clk;
  logic        in_nrst;
  int          total = 0;
  int          bad = 0;
  int unsigned addr = 0;
  logic [15:0] mem [0:15];
  vec_t        tbl [8];

  al422_bam_multi_if #(.CHAINS(2), .ROW_BITS(1)) bus ();

  al422_bam_multi #(
    .COLS(4), .ROW_BITS(1), .BAM_BITS(2), .CHAINS(2), .BASE_TICKS(2), .DEAD_TICKS(1)
  ) dut (
    .in_clk  (in_clk),
    .in_nrst (in_nrst),
    .bus     (bus)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  always @(posedge in_clk) begin
    if (!bus.al422_nrst_out)    addr <= 0;
    else if (!bus.al422_re_out) addr <= addr + 1;
  end
  assign bus.in_data = mem[addr[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic apply_reset(input int cycles);
    in_nrst = 1'b0;
    repeat (cycles) @(negedge in_clk);
    check("reset ctrl {nrst,re,clk,lat,oe,done}",
          {bus.al422_nrst_out, bus.al422_re_out, bus.led_clk_out, bus.led_lat_out,
           bus.led_oe_out, bus.frame_done}, 6'b010010);
    check("reset led_row", bus.led_row, 0);
    check("reset rgb", {bus.rgb1, bus.rgb2}, 0);
    in_nrst = 1'b1;
  endtask

  // Observes one frame starting from reset release, up to the next frame's first read.
  task automatic run_frame(input int on0, input int on1);
    int first_re = -1, done_at = -1, next_re = -1, re_cnt = 0, dones = 0;
    int lat_n = 0, word_n = 0, oe_bad = 0;
    int lat_at [4];
    int row_at [4];
    int oe_row [4];
    for (int i = 0; i < 4; i++) begin
      lat_at[i] = -100; row_at[i] = -1; oe_row[i] = 0;
    end
    for (int cyc = 1; cyc <= 200 && next_re < 0; cyc++) begin
      @(negedge in_clk);
      if (cyc == 1) check("fifo reset held after release", bus.al422_nrst_out, 0);
      if (bus.frame_done) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      if (!bus.al422_re_out) begin
        if (done_at >= 0) next_re = cyc;
        else begin
          if (first_re < 0) begin
            first_re = cyc;
            check("oe at first read", bus.led_oe_out, 1);
            check("fifo reset released at first read", bus.al422_nrst_out, 1);
          end
          re_cnt++;
        end
      end
      if (done_at < 0) begin
        if ((!bus.al422_re_out || bus.led_clk_out || bus.led_lat_out || !bus.al422_nrst_out)
            && !bus.led_oe_out) oe_bad++;
        if (bus.led_lat_out) begin
          if (lat_n < 4) begin
            lat_at[lat_n] = cyc;
            row_at[lat_n] = int'(bus.led_row);
          end
          lat_n++;
        end else if (!bus.led_oe_out && lat_n >= 1 && lat_n <= 4) begin
          oe_row[lat_n-1]++;
        end
        if (bus.led_clk_out) begin
          if (word_n < 16) begin
            check($sformatf("rgb1 word %0d", word_n), bus.rgb1, tbl[word_n % 8].rgb1);
            check($sformatf("rgb2 word %0d", word_n), bus.rgb2, tbl[word_n % 8].rgb2);
          end
          word_n++;
        end
      end
    end
    check("edges to first read", first_re, 2);
    check("reads per frame", re_cnt, 16);
    check("words shifted", word_n, 16);
    check("frame length", done_at - first_re, 52);
    check("frst length", next_re - done_at, 2);
    check("frame_done pulses", dones, 1);
    check("latches per frame", lat_n, 4);
    check("row cycle p0r0", lat_at[1] - lat_at[0], 12);
    check("row cycle p0r1", lat_at[2] - lat_at[1], 12);
    check("row cycle p1r0", lat_at[3] - lat_at[2], 14);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("led_row at latch %0d", r), row_at[r], r % 2);
      check($sformatf("oe low cycles row %0d", r), oe_row[r], (r < 2) ? on0 : on1);
    end
    check("oe low outside display", oe_bad, 0);
  endtask

  initial begin
    int lats, waited, seen;
    in_nrst = 1'b0;
    tbl[0] = '{16'h002F, 6'h07, 6'h05};
    tbl[1] = '{16'h0107, 6'h0F, 6'h00};
    tbl[2] = '{16'hC0C0, 6'h00, 6'h00};
    tbl[3] = '{16'hFFEF, 6'h3F, 6'h3D};
    tbl[4] = '{16'h1A25, 6'h15, 6'h1C};
    tbl[5] = '{16'h6F80, 6'h38, 6'h28};
    tbl[6] = '{16'h0000, 6'h00, 6'h00};
    tbl[7] = '{16'h3A09, 6'h11, 6'h39};
    for (int i = 0; i < 16; i++) mem[i] = tbl[i % 8].word;

`ifdef AL422_BAM_MULTI_BRIGHTNESS_EN
    bus.brightness = 8'd127;
    apply_reset(4);
    run_frame(1, 2);
    bus.brightness = 8'd255;
    apply_reset(3);
    run_frame(2, 4);
`else
    apply_reset(4);
    run_frame(2, 4);
`endif

    // Abort during DISPLAY of plane 1, row 1.
    lats = 0;
    waited = 0;
    while (lats < 4 && waited < 100) begin
      @(negedge in_clk);
      waited++;
      if (bus.led_lat_out) lats++;
    end
    check("reached plane1 row1 latch", lats, 4);
    @(negedge in_clk);
    check("display before abort", bus.led_oe_out, 0);
    check("row before abort", bus.led_row, 1);
    in_nrst = 1'b0;
    @(negedge in_clk);
    check("abort oe", bus.led_oe_out, 1);
    check("abort led_row", bus.led_row, 0);
    check("abort lat", bus.led_lat_out, 0);
    check("abort fifo reset", bus.al422_nrst_out, 0);
    in_nrst = 1'b1;
    seen = 0;
    for (int cyc = 1; cyc <= 20 && seen == 0; cyc++) begin
      @(negedge in_clk);
      if (bus.led_clk_out) begin
        seen = cyc;
        check("restart rgb1 from addr 0", bus.rgb1, tbl[0].rgb1);
        check("restart rgb2 from addr 0", bus.rgb2, tbl[0].rgb2);
      end
    end
    check("first shift clock after restart", seen, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/al422_bam_multi.md
Name: al422_bam_multi

Overview:
- Parametrised successor of the single-panel AL422-to-HUB75 BAM driver.
- Streams bitplane-ordered pixel words out of an AL422 video FIFO and shifts them into one or more HUB75 chains in parallel.
- Drives row address, latch and blanking, with binary-weighted on-times per bitplane.
- Sits between the AL422 read port and the panel connector. Row-address width, column count, BAM depth, chain count and on-time base are all configurable.

Parameters:
- COLS, 64: columns shifted per row (≥2).
- ROW_BITS, 4: width of led_row; rows per plane = 2**ROW_BITS.
- BAM_BITS, 6: bitplanes per frame (1..8).
- CHAINS, 1: parallel HUB75 chains, one FIFO byte lane each.
- BASE_TICKS, 32: on-time of plane 0, in in_clk cycles (≥1).
- DEAD_TICKS, 2: blanking cycles before each latch (≥1).

Ports:
- in_clk  in  1  system clock; all logic on its rising edge.
- in_nrst  in  1  reset, synchronous, active-low.
- in_data  in  8*CHAINS  FIFO read data.
  - Lane c = in_data[8c+7:8c].
  - Lane bits [2:0] = rgb1 {b,g,r}, [5:3] = rgb2 {b,g,r}, [7:6] ignored.
- al422_re_out  out  1  FIFO read enable, active-low.
- al422_nrst_out  out  1  FIFO read-pointer reset, active-low.
- led_clk_out  out  1  panel shift clock.
- led_lat_out  out  1  panel latch, active-high.
- led_oe_out  out  1  panel output enable, active-low.
- led_row  out  ROW_BITS  row address.
- rgb1  out  3*CHAINS  upper-half colour, per chain.
- rgb2  out  3*CHAINS  lower-half colour, per chain.
- frame_done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset values, held while in_nrst=0:
  - al422_nrst_out=0, al422_re_out=1
  - led_clk_out=0, led_lat_out=0, led_oe_out=1
  - led_row=0, rgb1=0, rgb2=0, frame_done=0
  - state=FRST; plane, row and column counters = 0.
- Reset asserted mid-frame aborts the frame on the next edge. No partial latch occurs.
- FIFO read contract:
  - The word on in_data is consumed on the rising edge where al422_re_out=0.
  - The block registers it into rgb1/rgb2 on that same edge (zero latency).
  - Exactly one word is consumed per column.
- Frame layout in the FIFO:
  - Plane-major, LSB plane first, then row 0..N-1, then column 0..COLS-1.
  - Words per frame = COLS * 2**ROW_BITS * BAM_BITS.
- FRST:
  - al422_nrst_out=0 for 2 cycles, then SHIFT_LO.
  - frame_done pulses on the FRST entry that follows a completed frame; it does not pulse after in_nrst.
- SHIFT_LO:
  - al422_re_out=0, led_clk_out=0; rgb registers load in_data.
  - Next state SHIFT_HI.
- SHIFT_HI:
  - al422_re_out=1, led_clk_out=1; the panel samples on this edge.
  - col++. Next: SHIFT_LO if col<COLS-1, else BLANK.
- BLANK: led_oe_out=1 for DEAD_TICKS cycles, then LATCH.
- LATCH (1 cycle):
  - led_lat_out=1.
  - led_row takes the current row on the same edge.
  - Next state DISPLAY.
- DISPLAY:
  - led_oe_out=0 for BASE_TICKS<<plane cycles.
  - Then row++ and go to SHIFT_LO.
  - On row wrap: plane++.
  - On plane wrap (last row of plane BAM_BITS-1): go to FRST.
- led_oe_out=1 in every state except DISPLAY.
- Display counter width must hold BASE_TICKS<<(BAM_BITS-1).
- All counters wrap to 0 exactly at their terminal value; no overflow past the terminal.

Optional Feature:
- Macro: AL422_BAM_MULTI_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [7:0].
  - Sampled at LATCH entry.
  - In DISPLAY, led_oe_out=0 only while tick < ((BASE_TICKS<<plane)*(brightness+1))>>8.
  - DISPLAY length itself is unchanged.
- Undefined: no port; led_oe_out=0 for the whole of DISPLAY.

Decomposition:
- Package al422_bam_pkg holds:
  - state enum {FRST, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY}
  - lane bit-offset constants (RGB1_LSB=0, RGB2_LSB=3)
  - a function for on-time width.
- One sub-module is natural: al422_bam_timer, a loadable down-counter shared by BLANK, DISPLAY and FRST.

Test Plan:
All scenarios use COLS=4, ROW_BITS=1, BAM_BITS=2, BASE_TICKS=2, DEAD_TICKS=1, and model the FIFO as an array whose address advances when al422_re_out=0.
- Reset release: in_nrst 0→1 → al422_nrst_out low for exactly 2 cycles, then first al422_re_out=0 with led_oe_out=1. Outputs hold reset values during reset.
- Single frame:
  - 16 re_out pulses between FRST phases.
  - Row cycle lengths are 4*2+1+1+2=12 for plane 0 and 4*2+1+1+4=14 for plane 1.
  - Total 52 cycles plus 2 FRST; one frame_done pulse.
- Data mapping: word 0x2F in lane 0 → rgb1=3'b111 and rgb2=3'b101 on the edge of its SHIFT_LO. Bits 7:6 have no effect.
- Multi-chain: CHAINS=2, word 0x0107 → rgb1[2:0]=7, rgb1[5:3]=1, rgb2=0.
- Mid-frame reset: in_nrst=0 during DISPLAY of plane 1 row 1 → next edge led_oe_out=1 and led_row=0. After release, the frame restarts at FIFO address 0.
- Brightness (macro on): brightness=127, plane 1 → led_oe_out low for 2 of the 4 DISPLAY cycles. brightness=255 → low for all 4.
